hex_line_tx: RTL and testbench



---
 rtl/hex_line_tx_pkg.sv | 27 ++
 rtl/hex_line_tx.sv | 131 +++++++++++++
 tb/tb_hex_line_tx.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/hex_line_tx_pkg.sv
// Shared types and ASCII helpers for hex_line_tx.
// The PREFIX state is only reachable when HEX_LINE_TX_PREFIX_EN is defined.
package hex_line_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREFIX,
        DIGIT,
        CR,
        LF
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_X  = 8'h78;
    // 'A' minus 10, so nibble 10..15 lands on 'A'..'F'
    localparam logic [7:0] ASCII_A_M10 = 8'h37;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            return ASCII_0 + {4'h0, nibble};
        end
        return ASCII_A_M10 + {4'h0, nibble};
    endfunction

endpackage

// File: rtl/hex_line_tx.sv
// Prints one captured WIDTH-bit word as an uppercase hex line (optional CR LF) on a byte stream.
// Define HEX_LINE_TX_PREFIX_EN to emit a leading "0x" before the digits.
module hex_line_tx
    import hex_line_tx_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NEWLINE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt, shifted;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [7:0]       tx_data_nxt;
    logic             tx_valid_nxt, busy_nxt, done_nxt;
    logic             xfer, finish;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            cnt      <= cnt_nxt;
            tx_data  <= tx_data_nxt;
            tx_valid <= tx_valid_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    // The next character is computed alongside the handshake so tx_data stays a register.
    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        cnt_nxt      = cnt;
        tx_data_nxt  = tx_data;
        tx_valid_nxt = tx_valid;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        finish       = 1'b0;
        shifted      = shreg << 4;
        xfer         = tx_valid && tx_ready;

        case (state)
            IDLE: begin
                if (start) begin
                    shreg_nxt    = data;
                    cnt_nxt      = LAST;
                    busy_nxt     = 1'b1;
                    tx_valid_nxt = 1'b1;
`ifdef HEX_LINE_TX_PREFIX_EN
                    state_nxt    = PREFIX;
                    tx_data_nxt  = ASCII_0;
`else
                    state_nxt    = DIGIT;
                    tx_data_nxt  = hex_ascii(data[WIDTH-1 -: 4]);
`endif
                end
            end
`ifdef HEX_LINE_TX_PREFIX_EN
            PREFIX: begin
                // The presented byte itself tells which half of "0x" is in flight.
                if (xfer) begin
                    if (tx_data == ASCII_0) begin
                        tx_data_nxt = ASCII_X;
                    end else begin
                        state_nxt   = DIGIT;
                        tx_data_nxt = hex_ascii(shreg[WIDTH-1 -: 4]);
                    end
                end
            end
`endif
            DIGIT: begin
                if (xfer) begin
                    if (cnt == '0) begin
                        if (NEWLINE != 0) begin
                            state_nxt   = CR;
                            tx_data_nxt = ASCII_CR;
                        end else begin
                            finish = 1'b1;
                        end
                    end else begin
                        shreg_nxt   = shifted;
                        cnt_nxt     = cnt - 1'b1;
                        tx_data_nxt = hex_ascii(shifted[WIDTH-1 -: 4]);
                    end
                end
            end
            CR: begin
                if (xfer) begin
                    state_nxt   = LF;
                    tx_data_nxt = ASCII_LF;
                end
            end
            LF: begin
                if (xfer) begin
                    finish = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (finish) begin
            state_nxt    = IDLE;
            busy_nxt     = 1'b0;
            tx_valid_nxt = 1'b0;
            done_nxt     = 1'b1;
        end
    end

endmodule

// File: tb/tb_hex_line_tx.sv
// Self-checking bench for hex_line_tx: three parameter sets checked against an index-based line model.
// Honours HEX_LINE_TX_PREFIX_EN when the design is built with it.
module tb_hex_line_tx;

`ifdef HEX_LINE_TX_PREFIX_EN
    localparam int PFX = 2;
`else
    localparam int PFX = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  start_v;
    logic [2:0]  ready_v;
    logic [2:0]  busy_v, done_v, valid_v;
    logic [7:0]  txd_v [3];
    logic [15:0] d0;
    logic [3:0]  d1;
    logic [63:0] d2;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    hex_line_tx #(.WIDTH(16), .NEWLINE(1)) u_w16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .data(d0),
        .busy(busy_v[0]), .done(done_v[0]), .tx_data(txd_v[0]),
        .tx_valid(valid_v[0]), .tx_ready(ready_v[0]));

    hex_line_tx #(.WIDTH(4), .NEWLINE(0)) u_w4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .data(d1),
        .busy(busy_v[1]), .done(done_v[1]), .tx_data(txd_v[1]),
        .tx_valid(valid_v[1]), .tx_ready(ready_v[1]));

    hex_line_tx #(.WIDTH(64), .NEWLINE(1)) u_w64 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .data(d2),
        .busy(busy_v[2]), .done(done_v[2]), .tx_data(txd_v[2]),
        .tx_valid(valid_v[2]), .tx_ready(ready_v[2]));

    // Transfer log: a byte is logged at the negedge before the posedge that completes it.
    logic [7:0]  got0[$], got1[$], got2[$];
    int unsigned done_cnt [3] = '{0, 0, 0};

    always @(negedge clk) begin
        if (valid_v[0] && ready_v[0]) got0.push_back(txd_v[0]);
        if (valid_v[1] && ready_v[1]) got1.push_back(txd_v[1]);
        if (valid_v[2] && ready_v[2]) got2.push_back(txd_v[2]);
        for (int k = 0; k < 3; k++) if (done_v[k]) done_cnt[k]++;
    end

    function automatic int width_of(input int k);
        return (k == 0) ? 16 : (k == 1) ? 4 : 64;
    endfunction

    function automatic int nl_of(input int k);
        return (k == 1) ? 0 : 1;
    endfunction

    function automatic int exp_len(input int k);
        return PFX + width_of(k) / 4 + 2 * nl_of(k);
    endfunction

    // Character i of the line the spec describes for word d on DUT k.
    function automatic logic [7:0] exp_byte(input int k, input logic [63:0] d, input int i);
        int nd, j, nib;
        nd = width_of(k) / 4;
        if (i < PFX) return (i == 0) ? 8'h30 : 8'h78;
        j = i - PFX;
        if (j < nd) begin
            nib = int'((d >> (4 * (nd - 1 - j))) & 64'hF);
            return (nib < 10) ? 8'(48 + nib) : 8'(55 + nib);
        end
        return (j == nd) ? 8'h0D : 8'h0A;
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0: return got0.size();
            1: return got1.size();
            default: return got2.size();
        endcase
    endfunction

    function automatic logic [7:0] qget(input int k, input int idx);
        if (idx >= qsize(k)) return 8'hxx;
        case (k)
            0: return got0[idx];
            1: return got1[idx];
            default: return got2[idx];
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int k, input logic st, input logic [63:0] dat, input logic rdy);
        case (k)
            0: begin start_v[0] = st; d0 = dat[15:0]; ready_v[0] = rdy; end
            1: begin start_v[1] = st; d1 = dat[3:0];  ready_v[1] = rdy; end
            default: begin start_v[2] = st; d2 = dat; ready_v[2] = rdy; end
        endcase
    endtask

    // mode 0: ready always high; 1: low 5 cycles then toggling; 2: random ready.
    task automatic run_line(input int k, input logic [63:0] dat, input int mode,
                            input bit prestarted, input bit mid, input bit chain,
                            input logic [63:0] next_dat);
        int          base, len, vc;
        int unsigned dc0;
        bit          seen_done, rdy, st;
        logic [63:0] dnew;
        base = qsize(k);
        dc0  = done_cnt[k];
        len  = exp_len(k);
        vc   = 0;
        seen_done = 1'b0;
        if (!prestarted) begin
            @(posedge clk); #1;
            drive(k, 1'b1, dat, 1'b0);
        end
        for (int c = 0; c < 400 && !seen_done; c++) begin
            @(posedge clk); #1;
            case (mode)
                0: rdy = 1'b1;
                1: rdy = (c >= 5) && (c % 2 == 1);
                default: rdy = 1'($urandom % 2);
            endcase
            st   = 1'b0;
            dnew = {$urandom, $urandom};
            if (mid && c == 2) begin st = 1'b1; dnew = 64'hFFFF; end
            if (chain && c == len - 1) begin st = 1'b1; dnew = 64'hFFFF; end
            if (chain && c == len) begin st = 1'b1; dnew = next_dat; end
            drive(k, st, dnew, rdy);
            @(negedge clk); #1;
            if (c == 0) begin
                check("latency_valid", 64'(valid_v[k]), 64'd1);
                check("busy_first", 64'(busy_v[k]), 64'd1);
            end
            if (valid_v[k]) vc++;
            if (valid_v[k] && !rdy)
                check("stall_hold", 64'(txd_v[k]), 64'(exp_byte(k, dat, qsize(k) - base)));
            if (done_v[k]) begin
                seen_done = 1'b1;
                check("done_gap_valid", 64'(valid_v[k]), 64'd0);
                check("done_busy", 64'(busy_v[k]), 64'd0);
            end
        end
        check("timeout", 64'(seen_done), 64'd1);
        check("line_len", 64'(qsize(k) - base), 64'(len));
        for (int i = 0; i < len; i++)
            check("line_byte", 64'(qget(k, base + i)), 64'(exp_byte(k, dat, i)));
        check("done_once", 64'(done_cnt[k] - dc0), 64'd1);
        if (mode == 0) check("valid_cycles", 64'(vc), 64'(len));
    endtask

    initial begin
        int          base, s;
        int unsigned dc0;
        rst_n   = 1'b0;
        start_v = '0;
        ready_v = '0;
        d0 = '0; d1 = '0; d2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_busy", 64'(busy_v[k]), 64'd0);
            check("rst_done", 64'(done_v[k]), 64'd0);
            check("rst_valid", 64'(valid_v[k]), 64'd0);
            check("rst_txdata", 64'(txd_v[k]), 64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_line(0, 64'hA5C3, 0, 1'b0, 1'b0, 1'b0, 64'h0);
        run_line(0, 64'h09F0, 1, 1'b0, 1'b0, 1'b0, 64'h0);
        run_line(0, 64'($urandom & 16'hFFFF), 0, 1'b0, 1'b1, 1'b1, 64'h1234);
        run_line(0, 64'h1234, 0, 1'b1, 1'b0, 1'b0, 64'h0);

        // Reset two transfers into a line: the line is abandoned with no done pulse.
        base = qsize(0);
        dc0  = done_cnt[0];
        @(posedge clk); #1;
        drive(0, 1'b1, 64'h5A5A, 1'b1);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            drive(0, 1'b0, {$urandom, $urandom}, 1'b1);
            @(negedge clk); #1;
            if (qsize(0) - base >= 2) break;
        end
        check("pre_reset_bytes", 64'(qsize(0) - base), 64'd2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("abort_valid", 64'(valid_v[0]), 64'd0);
        check("abort_busy", 64'(busy_v[0]), 64'd0);
        s = qsize(0);
        repeat (10) @(posedge clk);
        @(negedge clk); #1;
        check("abort_no_bytes", 64'(qsize(0)), 64'(s));
        check("abort_no_done", 64'(done_cnt[0]), 64'(dc0));
        run_line(0, 64'hBEEF, 0, 1'b0, 1'b0, 1'b0, 64'h0);

        run_line(0, 64'h00FF, 0, 1'b0, 1'b0, 1'b0, 64'h0);
        run_line(1, 64'hB, 0, 1'b0, 1'b0, 1'b0, 64'h0);
        run_line(1, 64'($urandom & 4'hF), 2, 1'b0, 1'b0, 1'b0, 64'h0);
        run_line(2, 64'h0123456789ABCDEF, 0, 1'b0, 1'b0, 1'b0, 64'h0);
        run_line(2, {$urandom, $urandom}, 2, 1'b0, 1'b0, 1'b0, 64'h0);
        for (int n = 0; n < 6; n++)
            run_line(0, 64'($urandom & 16'hFFFF), 2, 1'b0, 1'b0, 1'b0, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
